// File: rtl/updi_unlock_sequencer.sv
// UPDI key-unlock sequencer: KEY, key-status check, system reset pulse and SYS_STATUS
// polling, driven through the shared updi_interface TX/RX handshake.
module updi_unlock_sequencer #(
   parameter int POLL_GAP_CLK   = 1000,
   parameter int MAX_POLLS      = 256,
   parameter int RX_TIMEOUT_CLK = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] error_code,
   output logic [1:0] cmd_opcode,
   output logic [3:0] cmd_cs_addr,
   output logic [7:0] cmd_data,
   output logic       cmd_key_sel,
   output logic       tx_start,
   input  logic       tx_ready,
   output logic       rx_start,
   output logic [3:0] rx_n_bytes,
   input  logic       rx_ready,
   input  logic [7:0] rx_fifo_data,
   output logic       rx_fifo_rd_en,
   input  logic       rx_fifo_empty
);
   localparam int RXC_W  = (RX_TIMEOUT_CLK > 1) ? $clog2(RX_TIMEOUT_CLK) : 1;
   localparam int POLL_W = $clog2(MAX_POLLS + 1);
   localparam int GAP_W  = $clog2(POLL_GAP_CLK + 1);

   localparam logic [1:0] OP_LDCS = 2'd0, OP_STCS = 2'd1, OP_KEY = 2'd2;
   localparam logic [3:0] ASI_KEY_STATUS = 4'h7, ASI_RESET_REQ = 4'h8, ASI_SYS_STATUS = 4'hB;
   localparam logic [2:0] EC_NONE = 3'd0, EC_KEY = 3'd1, EC_POLL = 3'd2, EC_RX = 3'd3, EC_ABORT = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE, S_KEY, S_TXW, S_KSTAT_REQ, S_RXS, S_RXW, S_KSTAT_CHK,
      S_RST_SET, S_RST_CLR, S_GAP, S_POLL_REQ, S_POLL_CHK, S_FIN
   } state_t;

   state_t              r_state, r_ret_tx, r_ret_rx;
   logic                r_arm, r_mode, r_busy, r_done, r_error;
   logic [2:0]          r_code;
   logic [1:0]          r_cmd_opcode;
   logic [3:0]          r_cmd_cs_addr;
   logic [7:0]          r_cmd_data;
   logic                r_cmd_key_sel, r_tx_start, r_rx_start, r_rd_en;
   logic [7:0]          r_rx_byte;
   logic [RXC_W-1:0]    r_rx_cnt;
   logic [GAP_W-1:0]    r_gap;
   logic [POLL_W-1:0]   r_polls;

   logic                w_issue, w_fin, w_key_ok, w_poll_ok;
   logic [1:0]          w_op;
   logic [3:0]          w_addr;
   logic [7:0]          w_data;
   logic [2:0]          w_fin_code;
   state_t              w_ret_tx, w_ret_rx;

   assign w_key_ok  = |(r_rx_byte & (r_mode ? 8'h08 : 8'h10));
   assign w_poll_ok = r_mode ? ~|(r_rx_byte & 8'h01) : |(r_rx_byte & 8'h08);

   // Command-issuing states: what to send and where to resume afterwards.
   always_comb begin
      w_issue  = 1'b0;
      w_op     = OP_LDCS;
      w_addr   = 4'h0;
      w_data   = 8'h00;
      w_ret_tx = S_IDLE;
      w_ret_rx = S_IDLE;
      case (r_state)
         S_KEY:       begin w_issue = 1'b1; w_op = OP_KEY; w_ret_tx = S_KSTAT_REQ; end
         S_KSTAT_REQ: begin w_issue = 1'b1; w_addr = ASI_KEY_STATUS; w_ret_tx = S_RXS; w_ret_rx = S_KSTAT_CHK; end
         S_RST_SET:   begin w_issue = 1'b1; w_op = OP_STCS; w_addr = ASI_RESET_REQ; w_data = 8'h59; w_ret_tx = S_RST_CLR; end
         S_RST_CLR:   begin w_issue = 1'b1; w_op = OP_STCS; w_addr = ASI_RESET_REQ; w_ret_tx = S_GAP; end
         S_POLL_REQ:  begin w_issue = 1'b1; w_addr = ASI_SYS_STATUS; w_ret_tx = S_RXS; w_ret_rx = S_POLL_CHK; end
         default: ;
      endcase
   end

   // Termination conditions; abort takes priority over everything else.
   always_comb begin
      w_fin      = 1'b0;
      w_fin_code = EC_NONE;
      if (abort && r_state != S_IDLE && r_state != S_FIN) begin
         w_fin = 1'b1; w_fin_code = EC_ABORT;
      end else begin
         case (r_state)
            S_RXW:       if (rx_fifo_empty && r_rx_cnt == RXC_W'(RX_TIMEOUT_CLK - 1)) begin
                            w_fin = 1'b1; w_fin_code = EC_RX;
                         end
            S_KSTAT_CHK: if (!w_key_ok) begin w_fin = 1'b1; w_fin_code = EC_KEY; end
            S_POLL_CHK:  if (w_poll_ok) w_fin = 1'b1;
                         else if (r_polls == POLL_W'(MAX_POLLS - 1)) begin
                            w_fin = 1'b1; w_fin_code = EC_POLL;
                         end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE; r_ret_tx <= S_IDLE; r_ret_rx <= S_IDLE;
         r_arm <= 1'b0; r_mode <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_error <= 1'b0;
         r_code <= EC_NONE; r_cmd_opcode <= 2'd0; r_cmd_cs_addr <= 4'h0; r_cmd_data <= 8'h00;
         r_cmd_key_sel <= 1'b0; r_tx_start <= 1'b0; r_rx_start <= 1'b0; r_rd_en <= 1'b0;
         r_rx_byte <= 8'h00; r_rx_cnt <= '0; r_gap <= '0; r_polls <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_rx_start <= 1'b0;
         r_rd_en    <= 1'b0;
         r_done     <= 1'b0;
         if (w_fin) begin
            r_state <= S_FIN;
            r_code  <= w_fin_code;
            r_error <= (w_fin_code != EC_NONE);
            r_done  <= 1'b1;
         end else if (w_issue) begin
            if (tx_ready) begin
               r_cmd_opcode  <= w_op;
               r_cmd_cs_addr <= w_addr;
               r_cmd_data    <= w_data;
               r_cmd_key_sel <= r_mode;
               r_tx_start    <= 1'b1;
               r_ret_tx      <= w_ret_tx;
               r_ret_rx      <= w_ret_rx;
               r_arm         <= 1'b0;
               r_state       <= S_TXW;
            end
         end else begin
            case (r_state)
               S_IDLE: if (start) begin
                  r_mode  <= mode;
                  r_error <= 1'b0;
                  r_code  <= EC_NONE;
                  r_polls <= '0;
                  r_gap   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_KEY;
               end
               // tx_ready may still read high in the cycle right after tx_start.
               S_TXW: if (!r_arm) r_arm <= 1'b1;
                      else if (tx_ready) r_state <= r_ret_tx;
               S_RXS: if (rx_ready) begin
                  r_rx_start <= 1'b1;
                  r_rx_cnt   <= '0;
                  r_state    <= S_RXW;
               end
               S_RXW: if (!rx_fifo_empty) begin
                  r_rd_en   <= 1'b1;
                  r_rx_byte <= rx_fifo_data;
                  r_state   <= r_ret_rx;
               end else if (r_rx_cnt != '1) begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
               S_KSTAT_CHK: r_state <= S_RST_SET;
               S_GAP: if (r_gap == GAP_W'(POLL_GAP_CLK - 1)) begin
                  r_gap   <= '0;
                  r_state <= S_POLL_REQ;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
               S_POLL_CHK: begin
                  r_polls <= r_polls + 1'b1;
                  r_state <= S_GAP;
               end
               S_FIN: begin
                  r_busy  <= 1'b0;
                  r_gap   <= '0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_error;
   assign error_code    = r_code;
   assign cmd_opcode    = r_cmd_opcode;
   assign cmd_cs_addr   = r_cmd_cs_addr;
   assign cmd_data      = r_cmd_data;
   assign cmd_key_sel   = r_cmd_key_sel;
   assign tx_start      = r_tx_start;
   assign rx_start      = r_rx_start;
   assign rx_n_bytes    = 4'd1;
   assign rx_fifo_rd_en = r_rd_en;
endmodule
